trivium_seq_ctrl: RTL

- Sequencer for the Trivium keystream core. Handles one request at a time: latches key/IV/length, issues the core load, runs the 1152-step warm-up, then steps the core once per keystream bit.
- Packs keystream bits LSB-first into WORD_W-bit words and hands them to a consumer over a valid/ready interface, stalling the core under backpressure.
- Sits between the core and the encryption datapath that XORs words with payload.

---
 rtl/trivium_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/trivium_seq_ctrl.sv
// rtl/trivium_seq_ctrl.sv - Trivium core sequencer: load, warm-up, keystream word packing
// One request at a time; words leave over valid/ready and the core stalls under backpressure.
module trivium_seq_ctrl #(
  parameter int WORD_W = 32,
  parameter int WARMUP = 1152,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [79:0]       key,
  input  logic [79:0]       iv,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic [WORD_W-1:0] ks_word,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              ks_last,
  output logic              done,
  output logic [79:0]       core_key,
  output logic [79:0]       core_iv,
  output logic              core_load,
  output logic              core_step,
  input  logic              core_ks
);

  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0]  BIT_LAST = BW'(WORD_W - 1);
  localparam logic [10:0]    WU_LAST  = 11'(WARMUP - 1);
  localparam logic [LEN_W:0] ONE_W    = (LEN_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARMUP,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  wgen;
  logic [10:0]       wu_cnt;
  logic [BW-1:0]     bcnt;
  logic [WORD_W-2:0] sr;
  logic              accept;
  logic              run_step;
  logic              word_end;
  logic              last_end;

  assign accept   = ks_valid && ks_ready;
  // Hold off only the step that would complete a word while the output register is still occupied.
  assign run_step = (state == S_RUN) && (wgen < len_r) &&
                    !((bcnt == BIT_LAST) && ks_valid && !ks_ready);
  assign word_end = run_step && (bcnt == BIT_LAST);
  assign last_end = word_end && (({1'b0, wgen} + ONE_W) == {1'b0, len_r});

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_step = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start && (len != '0)) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        core_load = 1'b1;
        state_nxt = S_WARMUP;
      end
      S_WARMUP: begin
        core_step = 1'b1;
        if (wu_cnt == WU_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        core_step = run_step;
        // Entering FLUSH on the final transfer edge means wgen==len_r exactly while in FLUSH.
        if (last_end) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (accept) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      core_key <= '0;
      core_iv  <= '0;
      len_r    <= '0;
      wgen     <= '0;
      wu_cnt   <= '0;
      bcnt     <= '0;
      sr       <= '0;
      ks_word  <= '0;
      ks_valid <= 1'b0;
      ks_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE && start) begin
        if (len != '0) begin
          core_key <= key;
          core_iv  <= iv;
          len_r    <= len;
          wgen     <= '0;
          wu_cnt   <= '0;
          bcnt     <= '0;
        end else begin
          done <= 1'b1;
        end
      end
      if (state == S_WARMUP) wu_cnt <= wu_cnt + 11'd1;
      if (run_step && !word_end) begin
        sr[bcnt] <= core_ks;
        bcnt     <= bcnt + BW'(1);
      end
      if (word_end) begin
        ks_word  <= {core_ks, sr};
        ks_valid <= 1'b1;
        ks_last  <= last_end;
        wgen     <= wgen + LEN_W'(1);
        bcnt     <= '0;
      end else if (accept) begin
        ks_valid <= 1'b0;
        ks_last  <= 1'b0;
      end
      if (state == S_FLUSH && accept) done <= 1'b1;
    end
  end

endmodule
